// File: rtl/ysyx_24110006_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory-port arbiter:
// FSM state encoding and master index constants.
package ysyx_24110006_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24110006_rr_pick.sv
// Two-way combinational request picker: round-robin against the last owner,
// or fixed priority with the LSU winning when RR_EN is 0.
module ysyx_24110006_rr_pick
  import ysyx_24110006_bus_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic req_0,
  input  logic req_1,
  input  logic last_owner,
  output logic gnt_idx,
  output logic gnt_valid
);

  // Winner selection; a lone requester always wins regardless of mode.
  always_comb begin
    gnt_idx   = M_IFU;
    gnt_valid = req_0 | req_1;
    if (req_0 && req_1) begin
      if (RR_EN != 0) begin
        gnt_idx = ~last_owner;
      end else begin
        gnt_idx = M_LSU;
      end
    end else if (req_1) begin
      gnt_idx = M_LSU;
    end else begin
      gnt_idx = M_IFU;
    end
  end

endmodule

// File: rtl/ysyx_24110006_bus_arbiter.sv
// Two-master, one-slave memory port arbiter (IFU = master 0, LSU = master 1).
// Holds one outstanding transaction and routes its response to the owner only.
module ysyx_24110006_bus_arbiter
  import ysyx_24110006_bus_arbiter_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int RR_EN = 1
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_m0_req_valid,
  output logic            o_m0_req_ready,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic            i_m0_wen,
  input  logic [DW-1:0]   i_m0_wdata,
  input  logic [DW/8-1:0] i_m0_wmask,
  output logic            o_m0_resp_valid,
  output logic [DW-1:0]   o_m0_rdata,
  output logic            o_m0_resp_err,
  input  logic            i_m1_req_valid,
  output logic            o_m1_req_ready,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic            i_m1_wen,
  input  logic [DW-1:0]   i_m1_wdata,
  input  logic [DW/8-1:0] i_m1_wmask,
  output logic            o_m1_resp_valid,
  output logic [DW-1:0]   o_m1_rdata,
  output logic            o_m1_resp_err,
  output logic            o_s_req_valid,
  input  logic            i_s_req_ready,
  output logic [AW-1:0]   o_s_addr,
  output logic            o_s_wen,
  output logic [DW-1:0]   o_s_wdata,
  output logic [DW/8-1:0] o_s_wmask,
  input  logic            i_s_resp_valid,
  input  logic [DW-1:0]   i_s_rdata,
  input  logic            i_s_resp_err,
  output logic            o_busy,
  output logic            o_owner
);

  arb_state_e state_r;
  arb_state_e state_next_s;
  logic            owner_r;
  logic            rr_ptr_r;
  logic [AW-1:0]   addr_r;
  logic            wen_r;
  logic [DW-1:0]   wdata_r;
  logic [DW/8-1:0] wmask_r;

  logic            gnt_idx_s;
  logic            gnt_valid_s;
  logic            grant_s;
  logic            resp_fire_s;
  logic [AW-1:0]   sel_addr_s;
  logic            sel_wen_s;
  logic [DW-1:0]   sel_wdata_s;
  logic [DW/8-1:0] sel_wmask_s;

  // rr_ptr_r names the preferred master, so the last owner is its complement.
  ysyx_24110006_rr_pick #(
    .RR_EN (RR_EN)
  ) u_pick (
    .req_0      (i_m0_req_valid),
    .req_1      (i_m1_req_valid),
    .last_owner (~rr_ptr_r),
    .gnt_idx    (gnt_idx_s),
    .gnt_valid  (gnt_valid_s)
  );

  assign grant_s = (state_r == IDLE) && gnt_valid_s;

  // Winner's request fields, captured on grant.
  always_comb begin
    sel_addr_s  = i_m0_addr;
    sel_wen_s   = i_m0_wen;
    sel_wdata_s = i_m0_wdata;
    sel_wmask_s = i_m0_wmask;
    if (gnt_idx_s == M_LSU) begin
      sel_addr_s  = i_m1_addr;
      sel_wen_s   = i_m1_wen;
      sel_wdata_s = i_m1_wdata;
      sel_wmask_s = i_m1_wmask;
    end else begin
      sel_addr_s  = i_m0_addr;
      sel_wen_s   = i_m0_wen;
      sel_wdata_s = i_m0_wdata;
      sel_wmask_s = i_m0_wmask;
    end
  end

  // Next-state logic; a response is only accepted while a request is in flight.
  always_comb begin
    state_next_s = state_r;
    resp_fire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (i_s_req_ready && i_s_resp_valid) begin
          resp_fire_s  = 1'b1;
          state_next_s = IDLE;
        end else if (i_s_req_ready) begin
          state_next_s = RESP;
        end else begin
          state_next_s = REQ;
        end
      end
      RESP: begin
        if (i_s_resp_valid) begin
          resp_fire_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
        resp_fire_s  = 1'b0;
      end
    endcase
  end

  // State, ownership and request capture registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= IDLE;
      owner_r  <= M_IFU;
      rr_ptr_r <= M_IFU;
      addr_r   <= {AW{1'b0}};
      wen_r    <= 1'b0;
      wdata_r  <= {DW{1'b0}};
      wmask_r  <= {(DW/8){1'b0}};
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        owner_r  <= gnt_idx_s;
        rr_ptr_r <= ~gnt_idx_s;
        addr_r   <= sel_addr_s;
        wen_r    <= sel_wen_s;
        wdata_r  <= sel_wdata_s;
        wmask_r  <= sel_wmask_s;
      end
    end
  end

  // Handshake and response routing toward the masters.
  always_comb begin
    o_m0_req_ready  = 1'b0;
    o_m1_req_ready  = 1'b0;
    o_m0_resp_valid = 1'b0;
    o_m1_resp_valid = 1'b0;
    if (grant_s) begin
      o_m0_req_ready = (gnt_idx_s == M_IFU);
      o_m1_req_ready = (gnt_idx_s == M_LSU);
    end else begin
      o_m0_req_ready = 1'b0;
      o_m1_req_ready = 1'b0;
    end
    if (resp_fire_s) begin
      o_m0_resp_valid = (owner_r == M_IFU);
      o_m1_resp_valid = (owner_r == M_LSU);
    end else begin
      o_m0_resp_valid = 1'b0;
      o_m1_resp_valid = 1'b0;
    end
  end

  assign o_m0_rdata    = i_s_rdata;
  assign o_m1_rdata    = i_s_rdata;
  assign o_m0_resp_err = i_s_resp_err;
  assign o_m1_resp_err = i_s_resp_err;

  assign o_s_req_valid = (state_r == REQ);
  assign o_s_addr      = addr_r;
  assign o_s_wen       = wen_r;
  assign o_s_wdata     = wdata_r;
  assign o_s_wmask     = wmask_r;
  assign o_busy        = (state_r != IDLE);
  assign o_owner       = owner_r;

endmodule

// File: tb/tb_ysyx_24110006_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one set of
// master/slave stimulus; the bench acts as both masters and the slave.
module tb_ysyx_24110006_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_req_valid, m0_wen, m1_req_valid, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        s_req_ready, s_resp_valid, s_resp_err;
  logic [31:0] s_rdata;

  logic        a_m0_req_ready, a_m0_resp_valid, a_m0_resp_err;
  logic        a_m1_req_ready, a_m1_resp_valid, a_m1_resp_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
  logic        a_s_req_valid, a_s_wen, a_busy, a_owner;
  logic [3:0]  a_s_wmask;

  logic        f_m0_req_ready, f_m0_resp_valid, f_m0_resp_err;
  logic        f_m1_req_ready, f_m1_resp_valid, f_m1_resp_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic        f_s_req_valid, f_s_wen, f_busy, f_owner;
  logic [3:0]  f_s_wmask;

  ysyx_24110006_bus_arbiter #(.AW(32), .DW(32), .RR_EN(1)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_m0_req_valid(m0_req_valid), .o_m0_req_ready(a_m0_req_ready),
    .i_m0_addr(m0_addr), .i_m0_wen(m0_wen), .i_m0_wdata(m0_wdata), .i_m0_wmask(m0_wmask),
    .o_m0_resp_valid(a_m0_resp_valid), .o_m0_rdata(a_m0_rdata), .o_m0_resp_err(a_m0_resp_err),
    .i_m1_req_valid(m1_req_valid), .o_m1_req_ready(a_m1_req_ready),
    .i_m1_addr(m1_addr), .i_m1_wen(m1_wen), .i_m1_wdata(m1_wdata), .i_m1_wmask(m1_wmask),
    .o_m1_resp_valid(a_m1_resp_valid), .o_m1_rdata(a_m1_rdata), .o_m1_resp_err(a_m1_resp_err),
    .o_s_req_valid(a_s_req_valid), .i_s_req_ready(s_req_ready),
    .o_s_addr(a_s_addr), .o_s_wen(a_s_wen), .o_s_wdata(a_s_wdata), .o_s_wmask(a_s_wmask),
    .i_s_resp_valid(s_resp_valid), .i_s_rdata(s_rdata), .i_s_resp_err(s_resp_err),
    .o_busy(a_busy), .o_owner(a_owner)
  );

  ysyx_24110006_bus_arbiter #(.AW(32), .DW(32), .RR_EN(0)) dut_fp (
    .i_clock(clk), .i_reset(rst),
    .i_m0_req_valid(m0_req_valid), .o_m0_req_ready(f_m0_req_ready),
    .i_m0_addr(m0_addr), .i_m0_wen(m0_wen), .i_m0_wdata(m0_wdata), .i_m0_wmask(m0_wmask),
    .o_m0_resp_valid(f_m0_resp_valid), .o_m0_rdata(f_m0_rdata), .o_m0_resp_err(f_m0_resp_err),
    .i_m1_req_valid(m1_req_valid), .o_m1_req_ready(f_m1_req_ready),
    .i_m1_addr(m1_addr), .i_m1_wen(m1_wen), .i_m1_wdata(m1_wdata), .i_m1_wmask(m1_wmask),
    .o_m1_resp_valid(f_m1_resp_valid), .o_m1_rdata(f_m1_rdata), .o_m1_resp_err(f_m1_resp_err),
    .o_s_req_valid(f_s_req_valid), .i_s_req_ready(s_req_ready),
    .o_s_addr(f_s_addr), .o_s_wen(f_s_wen), .o_s_wdata(f_s_wdata), .o_s_wmask(f_s_wmask),
    .i_s_resp_valid(s_resp_valid), .i_s_rdata(s_rdata), .i_s_resp_err(s_resp_err),
    .o_busy(f_busy), .o_owner(f_owner)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One single-requester transaction; slave timing comes from the record.
  typedef struct {
    logic        m1;        // requesting master index, also the expected owner
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    int          rdy_dly;   // REQ cycles with slave ready low
    logic        same;      // response in the same cycle as ready
    int          rsp_wait;  // RESP cycles before the response
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  task automatic idle_inputs();
    m0_req_valid = 1'b0; m0_wen = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wmask = 4'h0;
    m1_req_valid = 1'b0; m1_wen = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_err = 1'b0; s_rdata = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] own_pair;
    own_pair = v.m1 ? 2'b10 : 2'b01;
    @(negedge clk);
    if (v.m1) begin
      m1_req_valid = 1'b1; m1_addr = v.addr; m1_wdata = v.wdata; m1_wmask = v.wmask; m1_wen = v.wen;
    end else begin
      m0_req_valid = 1'b1; m0_addr = v.addr; m0_wdata = v.wdata; m0_wmask = v.wmask; m0_wen = v.wen;
    end
    s_rdata = v.rdata; s_resp_err = v.err;
    #1;
    chk("grant_ready", {a_m1_req_ready, a_m0_req_ready}, own_pair);
    chk("fp_grant_ready", {f_m1_req_ready, f_m0_req_ready}, own_pair);
    @(negedge clk);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    for (int c = 0; c <= v.rdy_dly; c++) begin
      s_req_ready  = (c == v.rdy_dly);
      s_resp_valid = (c == v.rdy_dly) && v.same;
      #1;
      chk("s_req_valid", a_s_req_valid, 1'b1);
      chk("s_fields", {a_s_addr, a_s_wdata, a_s_wmask, a_s_wen}, {v.addr, v.wdata, v.wmask, v.wen});
      chk("owner", a_owner, v.m1);
      if (!(c == v.rdy_dly && v.same)) begin
        chk("no_early_resp", {a_m1_resp_valid, a_m0_resp_valid}, 2'b00);
        @(negedge clk);
      end
    end
    if (!v.same) begin
      s_req_ready = 1'b0;
      s_resp_valid = 1'b0;
      for (int w = 0; w < v.rsp_wait; w++) begin
        #1;
        chk("resp_wait", {a_busy, a_s_req_valid, a_m1_resp_valid, a_m0_resp_valid}, 4'b1000);
        @(negedge clk);
      end
      s_resp_valid = 1'b1;
      #1;
    end
    chk("resp_valid", {a_m1_resp_valid, a_m0_resp_valid}, own_pair);
    chk("resp_data", {(v.m1 ? a_m1_rdata : a_m0_rdata), (v.m1 ? a_m1_resp_err : a_m0_resp_err)},
        {v.rdata, v.err});
    @(negedge clk);
    s_req_ready = 1'b0; s_resp_valid = 1'b0;
    #1;
    chk("idle_after", {a_busy, a_m1_resp_valid, a_m0_resp_valid}, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    vecs[0] = '{1'b0, 32'h80000000, 32'h0,        4'h0, 1'b0, 0, 1'b0, 1, 32'h00100073, 1'b0};
    vecs[1] = '{1'b1, 32'h80001000, 32'hDEADBEEF, 4'h3, 1'b1, 3, 1'b0, 0, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 32'h80002000, 32'h0,        4'h0, 1'b0, 0, 1'b1, 0, 32'h12345678, 1'b1};
    vecs[3] = '{1'b0, 32'h80000010, 32'h11223344, 4'hF, 1'b1, 1, 1'b1, 0, 32'h0,        1'b0};
    vecs[4] = '{1'b0, 32'h80000020, 32'h0,        4'h0, 1'b0, 2, 1'b0, 2, 32'hCAFEF00D, 1'b1};
    vecs[5] = '{1'b1, 32'h8000FFFC, 32'h0,        4'h0, 1'b0, 0, 1'b0, 0, 32'hA5A5A5A5, 1'b0};

    #1;
    chk("reset_ctrl", {a_m0_req_ready, a_m1_req_ready, a_m0_resp_valid, a_m1_resp_valid,
                       a_s_req_valid, a_s_wen, a_busy, a_owner}, 8'h00);
    chk("reset_fields", {a_s_addr, a_s_wdata, a_s_wmask}, 68'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while waiting in RESP abandons the transaction.
    @(negedge clk);
    m1_req_valid = 1'b1; m1_addr = 32'h80003000; m1_wdata = 32'h55AA55AA; m1_wmask = 4'hC; m1_wen = 1'b1;
    @(negedge clk);
    m1_req_valid = 1'b0; s_req_ready = 1'b1;
    @(negedge clk);
    s_req_ready = 1'b0;
    #1;
    chk("in_resp", {a_busy, a_owner, a_s_req_valid}, 3'b110);
    rst = 1'b1; s_resp_valid = 1'b1;
    #1;
    chk("rst_mid_ctrl", {a_m0_req_ready, a_m1_req_ready, a_m0_resp_valid, a_m1_resp_valid,
                         a_s_req_valid, a_s_wen, a_busy, a_owner}, 8'h00);
    chk("rst_mid_fields", {a_s_addr, a_s_wdata, a_s_wmask}, 68'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stray_resp_idle", {a_busy, a_m1_resp_valid, a_m0_resp_valid}, 3'b000);
    chk("fp_stray_resp_idle", {f_busy, f_m1_resp_valid, f_m0_resp_valid}, 3'b000);
    @(negedge clk);
    s_resp_valid = 1'b0;
    #1;
    chk("idle_stays", {a_busy, a_s_req_valid}, 2'b00);

    // Both masters request continuously: RR alternates 0,1,0,1; fixed gives m1 every time.
    @(negedge clk);
    m0_req_valid = 1'b1; m0_addr = 32'h80000100;
    m1_req_valid = 1'b1; m1_addr = 32'h80000200;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", {a_m1_req_ready, a_m0_req_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("fp_grant", {f_m1_req_ready, f_m0_req_ready}, 2'b10);
      @(negedge clk);
      s_req_ready = 1'b1; s_resp_valid = 1'b1; s_rdata = 32'h100 + k;
      #1;
      chk("rr_addr", a_s_addr, (k % 2 == 1) ? 32'h80000200 : 32'h80000100);
      chk("rr_resp", {a_m1_resp_valid, a_m0_resp_valid}, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("fp_resp", {f_m1_resp_valid, f_m0_resp_valid}, 2'b10);
      @(negedge clk);
      s_req_ready = 1'b0; s_resp_valid = 1'b0;
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    #1;
    chk("end_idle", {a_busy, f_busy}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_bus_arbiter.md
Name: ysyx_24110006_bus_arbiter

Overview:
Two-master, one-slave arbiter. It shares the single memory port between the instruction fetch unit (master 0) and the load/store unit (master 1). Each transaction is a request (valid/ready handshake) followed by one response (resp_valid pulse). The block sits between IFU/LSU and the memory/DPI memory model. It registers the granted request and routes the response back to its owner only.

Parameters:
AW, 32, address width
DW, 32, data width (DW/8 mask bits)
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (master 1 wins)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_m0_req_valid  in  1  IFU request valid
o_m0_req_ready  out  1  IFU request accepted this cycle
i_m0_addr  in  AW  IFU address
i_m0_wen  in  1  IFU write enable (normally 0)
i_m0_wdata  in  DW  IFU write data
i_m0_wmask  in  DW/8  IFU byte mask
o_m0_resp_valid  out  1  IFU response pulse
o_m0_rdata  out  DW  IFU read data
o_m0_resp_err  out  1  IFU response error
i_m1_* / o_m1_*  same set as m0  LSU side
o_s_req_valid  out  1  slave request valid
i_s_req_ready  in  1  slave accepts request
o_s_addr  out  AW  slave address
o_s_wen  out  1  slave write enable
o_s_wdata  out  DW  slave write data
o_s_wmask  out  DW/8  slave byte mask
i_s_resp_valid  in  1  slave response valid
i_s_rdata  in  DW  slave read data
i_s_resp_err  in  1  slave error
o_busy  out  1  state != IDLE
o_owner  out  1  current/last granted master index

Behaviour:
- FSM has three states: IDLE, REQ, RESP. Reset is asynchronous to IDLE. On reset: o_s_req_valid=0, all resp_valid=0, all req_ready=0, o_s_addr/wdata/wmask/wen=0, owner=0, rr_ptr=0 (master 0 preferred first).
- Grant in IDLE:
  - If any req_valid is high, pick a winner. Fixed mode: m1 wins over m0. RR mode: the master != last owner wins when both request; a single requester always wins.
  - The winner's o_mX_req_ready is high combinationally in that same cycle. The loser's ready stays 0.
  - The request fields are captured into registers, owner is updated, and the FSM moves to REQ.
- REQ: o_s_req_valid=1 with the registered fields held stable. When i_s_req_ready=1, the FSM moves to RESP next cycle.
  - If i_s_resp_valid is also 1 in that same cycle, the response is forwarded immediately and the FSM moves to IDLE.
- RESP: wait for i_s_resp_valid.
  - On the resp_valid cycle, o_m<owner>_resp_valid=1 combinationally, with rdata and err passed through. The other master's resp_valid stays 0.
  - The FSM moves to IDLE next cycle.
- rdata/err outputs carry i_s_rdata/i_s_resp_err whenever resp_valid is low; masters only sample them when resp_valid is high.
- Minimum latency: request accepted at cycle 0, slave valid at cycle 1, ready at cycle 1, response earliest at cycle 1 (same cycle) or cycle 2. IDLE always costs one cycle between transactions, so back-to-back grants are ≥2 cycles apart.
- i_s_resp_valid arriving in IDLE is ignored and not forwarded.
- Masters must hold req_valid and fields stable until ready; dropping valid early is a protocol violation, behaviour unspecified.
- Masters always accept responses (no resp ready).
- rr_ptr updates only on grant.
- Reset asserted mid-transaction abandons it: FSM to IDLE, no response is delivered, and the slave must also be reset.
- No buffering beyond one outstanding transaction.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, RESP=2'd2)
  - master index constants M_IFU=0, M_LSU=1
- One sub-module, ysyx_24110006_rr_pick: 2-way combinational picker (requests, last owner, RR_EN) -> grant index and grant valid.
- Capture registers and FSM stay in the top block.

Test Plan:
- m0 read only, addr 0x80000000. Slave ready at cycle 1, resp at cycle 3 with rdata 0x00100073 -> m0_req_ready at cycle 0, s_req_valid cycles 1..1, m0_resp_valid exactly at cycle 3 with 0x00100073, m1_resp_valid never high.
- m1 write: addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011. Slave stalls ready for 3 cycles -> s_addr/wdata/wmask/wen held constant across the stall, one m1_resp_valid.
- Both request at cycle 0 with RR_EN=1 after reset -> m0 granted first, then m1 on the next grant. Repeated simultaneous requests alternate 0,1,0,1.
- Both request with RR_EN=0 -> m1 always granted while m1 keeps requesting; m0 waits.
- Slave asserts ready and resp_valid in the same REQ cycle with err=1 -> owner gets resp_valid and err=1 that cycle, o_busy low next cycle.
- Reset asserted in RESP, and a stray slave resp_valid is injected while in IDLE -> all outputs 0 immediately on reset, no resp_valid forwarded to any master.
